// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Key codes, operator encoding and FSM state encodings shared
//               by the keypad debounce and operand-entry logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_EQ  = 3'd4;

    typedef logic [1:0] deb_state_t;
    localparam deb_state_t c_DEB_IDLE         = 2'd0;
    localparam deb_state_t c_DEB_PRESS_WAIT   = 2'd1;
    localparam deb_state_t c_DEB_HELD         = 2'd2;
    localparam deb_state_t c_DEB_RELEASE_WAIT = 2'd3;

    typedef logic [0:0] entry_state_t;
    localparam entry_state_t c_ENT_ENTRY = 1'b0;
    localparam entry_state_t c_ENT_SEND  = 1'b1;

    // Only meaningful for operator/equals codes (A..D, F).
    function automatic logic [2:0] key_to_op(input logic [3:0] code);
        logic [2:0] op;
        op = OP_EQ;
        case (code)
            KEY_ADD: op = OP_ADD;
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_EQ;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Turns the raw, bouncing key stream into single-cycle press
//               events once a code has been stable for DEBOUNCE_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    output logic       press,
    output logic [3:0] press_code
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] c_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] c_FULL = CW'(DEBOUNCE_CYCLES);

    deb_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_code;
    logic            r_press;

    // The counter reaching DEBOUNCE_CYCLES and the resulting action share one
    // edge, so the decision is taken when the count is one short.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_DEB_IDLE;
            r_cnt   <= '0;
            r_code  <= 4'h0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_state)
                c_DEB_IDLE: begin
                    if (key_valid) begin
                        r_state <= c_DEB_PRESS_WAIT;
                        r_code  <= key_value;
                        r_cnt   <= CW'(1);
                    end
                end
                c_DEB_PRESS_WAIT: begin
                    if (!key_valid) begin
                        r_state <= c_DEB_IDLE;
                        r_cnt   <= '0;
                    end else if (key_value != r_code) begin
                        r_code <= key_value;
                        r_cnt  <= CW'(1);
                    end else if (r_cnt >= c_LAST) begin
                        r_cnt   <= c_FULL;
                        r_press <= 1'b1;
                        r_state <= c_DEB_HELD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                c_DEB_HELD: begin
                    if (!key_valid) begin
                        r_state <= c_DEB_RELEASE_WAIT;
                        r_cnt   <= CW'(1);
                    end
                end
                c_DEB_RELEASE_WAIT: begin
                    if (key_valid) begin
                        r_state <= c_DEB_HELD;
                    end else if (r_cnt >= c_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_DEB_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= c_DEB_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign press      = r_press;
    assign press_code = r_code;

endmodule

`default_nettype wire

// File: rtl/keypad_entry.sv
// ============================================================================
// Module      : keypad_entry
// Description : Debounced keypad operand entry; assembles BCD digits and hands
//               operand+operator tokens downstream over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int NDIGITS         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           key_value,
    input  logic                 key_valid,
    output logic [4*NDIGITS-1:0] entry_bcd,
    output logic [3:0]           entry_count,
    output logic                 overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NDIGITS-1:0] out_operand,
    output logic [2:0]           out_op
);

    localparam logic [3:0] c_MAX_COUNT = 4'(NDIGITS);

    logic                 w_press;
    logic [3:0]           w_code;
    logic [4*NDIGITS-1:0] w_shifted;

    entry_state_t         r_state;
    logic [4*NDIGITS-1:0] r_bcd;
    logic [3:0]           r_count;
    logic                 r_overflow;
    logic                 r_out_valid;
    logic [4*NDIGITS-1:0] r_out_operand;
    logic [2:0]           r_out_op;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .key_value  (key_value),
        .key_valid  (key_valid),
        .press      (w_press),
        .press_code (w_code)
    );

    always_comb begin
        w_shifted      = r_bcd << 4;
        w_shifted[3:0] = w_code;
    end

    // Presses that arrive while a token is outstanding are dropped on purpose.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ENT_ENTRY;
            r_bcd         <= '0;
            r_count       <= 4'd0;
            r_overflow    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_operand <= '0;
            r_out_op      <= 3'd0;
        end else begin
            case (r_state)
                c_ENT_ENTRY: begin
                    if (w_press) begin
                        if (w_code <= 4'd9) begin
                            if (r_count == c_MAX_COUNT) begin
                                r_overflow <= 1'b1;
                            end else if (r_count != 4'd0 || w_code != 4'd0) begin
                                r_bcd   <= w_shifted;
                                r_count <= r_count + 4'd1;
                            end
                        end else begin
                            r_bcd      <= '0;
                            r_count    <= 4'd0;
                            r_overflow <= 1'b0;
                            if (w_code != KEY_CLR) begin
                                r_out_operand <= r_bcd;
                                r_out_op      <= key_to_op(w_code);
                                r_out_valid   <= 1'b1;
                                r_state       <= c_ENT_SEND;
                            end
                        end
                    end
                end
                c_ENT_SEND: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ENT_ENTRY;
                    end
                end
                default: r_state <= c_ENT_ENTRY;
            endcase
        end
    end

    assign entry_bcd   = r_bcd;
    assign entry_count = r_count;
    assign overflow    = r_overflow;
    assign out_valid   = r_out_valid;
    assign out_operand = r_out_operand;
    assign out_op      = r_out_op;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// ============================================================================
// Module      : tb_keypad_entry
// Description : Directed self-checking bench for keypad_entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_entry;

    localparam int N  = 20;
    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      key_value = 4'h0;
    logic            key_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [4*ND-1:0] entry_bcd;
    logic [3:0]      entry_count;
    logic            overflow;
    logic            out_valid;
    logic [4*ND-1:0] out_operand;
    logic [2:0]      out_op;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keypad_entry #(
        .DEBOUNCE_CYCLES (N),
        .NDIGITS         (ND)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_value   (key_value),
        .key_valid   (key_valid),
        .entry_bcd   (entry_bcd),
        .entry_count (entry_count),
        .overflow    (overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_operand (out_operand),
        .out_op      (out_op)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_key(input logic [3:0] code, input int hold);
        key_value = code;
        key_valid = 1'b1;
        tick(hold);
        key_valid = 1'b0;
        tick(N + 2);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        check("rst_bcd",     32'(entry_bcd), 32'h0);
        check("rst_count",   32'(entry_count), 32'h0);
        check("rst_ovf",     32'(overflow), 32'h0);
        check("rst_valid",   32'(out_valid), 32'h0);
        check("rst_operand", 32'(out_operand), 32'h0);
        check("rst_op",      32'(out_op), 32'h0);

        // Clean press of 5: update visible exactly N+1 edges after first sample
        key_value = 4'h5;
        key_valid = 1'b1;
        tick(N);
        check("lat_before", 32'(entry_count), 32'h0);
        tick(1);
        check("lat_bcd",   32'(entry_bcd), 32'h0005);
        check("lat_count", 32'(entry_count), 32'h1);
        tick(3 * N - N - 1);
        check("hold_norepeat", 32'(entry_count), 32'h1);
        key_valid = 1'b0;
        tick(N + 2);
        check("release_bcd", 32'(entry_bcd), 32'h0005);

        press_key(KEY_CLR_T(), 25);
        check("clr_bcd",   32'(entry_bcd), 32'h0);
        check("clr_count", 32'(entry_count), 32'h0);

        // Bounce: toggles every 3 cycles, never stable long enough
        key_value = 4'h8;
        for (int i = 0; i < 50; i++) begin
            key_valid = ((i / 3) % 2 == 0);
            tick(1);
        end
        key_valid = 1'b0;
        tick(N + 5);
        check("bounce_bcd",   32'(entry_bcd), 32'h0);
        check("bounce_count", 32'(entry_count), 32'h0);

        press_key(4'h0, 25);
        check("lead0_count", 32'(entry_count), 32'h0);
        press_key(4'h1, 25);
        press_key(4'h2, 25);
        press_key(4'h3, 25);
        press_key(4'h4, 25);
        check("full_bcd",   32'(entry_bcd), 32'h1234);
        check("full_count", 32'(entry_count), 32'h4);
        check("full_ovf",   32'(overflow), 32'h0);
        press_key(4'h5, 25);
        check("drop_bcd", 32'(entry_bcd), 32'h1234);
        check("drop_ovf", 32'(overflow), 32'h1);
        press_key(4'hE, 25);
        check("clr_ovf", 32'(overflow), 32'h0);

        // Token 12 + add, consumer stalled
        press_key(4'h1, 25);
        press_key(4'h2, 25);
        out_ready = 1'b0;
        press_key(4'hA, 25);
        check("tok1_valid",   32'(out_valid), 32'h1);
        check("tok1_operand", 32'(out_operand), 32'h0012);
        check("tok1_op",      32'(out_op), 32'h0);
        check("tok1_bcd",     32'(entry_bcd), 32'h0);
        press_key(4'h7, 25);
        check("send_discard_bcd", 32'(entry_bcd), 32'h0);
        check("send_hold_valid",  32'(out_valid), 32'h1);
        check("send_hold_operand", 32'(out_operand), 32'h0012);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("accept_valid", 32'(out_valid), 32'h0);
        press_key(4'h7, 25);
        check("after_bcd", 32'(entry_bcd), 32'h0007);

        press_key(4'hC, 25);
        check("tok2_valid",   32'(out_valid), 32'h1);
        check("tok2_operand", 32'(out_operand), 32'h0007);
        check("tok2_op",      32'(out_op), 32'h2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("tok2_accept", 32'(out_valid), 32'h0);

        press_key(4'h9, 25);
        press_key(4'hE, 25);
        press_key(4'hF, 25);
        check("tok3_valid",   32'(out_valid), 32'h1);
        check("tok3_operand", 32'(out_operand), 32'h0);
        check("tok3_op",      32'(out_op), 32'h4);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst2_valid",   32'(out_valid), 32'h0);
        check("rst2_operand", 32'(out_operand), 32'h0);
        check("rst2_op",      32'(out_op), 32'h0);
        check("rst2_count",   32'(entry_count), 32'h0);
        press_key(4'h3, 25);
        check("rst2_bcd", 32'(entry_bcd), 32'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [3:0] KEY_CLR_T();
        return 4'hE;
    endfunction

endmodule

`default_nettype wire

// File: doc/keypad_entry.md
# keypad_entry

Downstream stage of the keypad scanner in the calculator input unit. Consumes the scanner's raw `value`/`valid` key stream, which repeats every sample and bounces. Debounces it into single key-press events and assembles digit presses into a BCD operand. Hands each completed operand plus its terminating operator to the calculator core over a valid/ready handshake.

## Interface
- `DEBOUNCE_CYCLES`, 20: consecutive stable `clk` cycles required to accept a press or a release; legal range 2..65535.
- `NDIGITS`, 4: maximum BCD digits per operand; legal range 1..8.
- `clk` in 1: the single system clock.
- `rst` in 1: synchronous, active-high reset.
- `key_value` in 4: raw key code from the scanner/decoder.
- `key_valid` in 1: raw "a key is down" indication, already combined with the scanner's sense signal.
- `entry_bcd` out 4*NDIGITS: live operand being typed, for the display; digit 0 is in the LSBs.
- `entry_count` out 4: number of digits entered, 0..NDIGITS.
- `overflow` out 1: sticky; set when a digit is dropped because the operand is full.
- `out_valid` out 1: token available.
- `out_ready` in 1: consumer accepts the token.
- `out_operand` out 4*NDIGITS: BCD operand of the token.
- `out_op` out 3: operator of the token. Encoding: 0 add, 1 sub, 2 mul, 3 div, 4 equals.

## Operation
- **Key codes** from the scanner:
  - 0–9: digits.
  - A: add. B: sub. C: mul. D: div.
  - E (`*`): clear.
  - F (`#`): equals.
- **Debounce FSM** (sub-module), states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: `key_valid`=1 moves to PRESS_WAIT and latches `key_value`; counter is set to 1.
  - PRESS_WAIT: counter increments while `key_valid`=1 and `key_value` equals the latched code.
    - `key_valid`=0 returns to IDLE.
    - A different code relatches the code and sets the counter to 1.
    - When the counter reaches DEBOUNCE_CYCLES: emit a one-cycle `press` pulse carrying the latched code, then go to HELD.
  - HELD: holding the key never repeats the press. `key_valid`=0 moves to RELEASE_WAIT with counter set to 1.
  - RELEASE_WAIT: counter increments while `key_valid`=0.
    - `key_valid`=1, with any code, returns to HELD.
    - When the counter reaches DEBOUNCE_CYCLES, go to IDLE.
- **Entry FSM**, states ENTRY and SEND. A press event is acted on only in ENTRY; presses arriving in SEND are discarded.
  - Digit d, `entry_count`=0, d=0: ignored (no leading zeros).
  - Digit d, 0 < `entry_count` < NDIGITS, or `entry_count`=0 with d≠0: shift `entry_bcd` left one digit, insert d at digit 0, increment `entry_count`.
  - Digit d, `entry_count`=NDIGITS: digit dropped, `overflow` set.
  - Clear: `entry_bcd`=0, `entry_count`=0, `overflow`=0.
  - Operator or equals:
    - Load `out_operand`=`entry_bcd` and `out_op`, and assert `out_valid`. An empty entry sends operand 0.
    - Clear `entry_bcd`, `entry_count` and `overflow`.
    - Go to SEND.
  - SEND: on `out_valid`&&`out_ready`, drop `out_valid` and return to ENTRY.
- **Handshake rules**:
  - `out_valid` never drops before acceptance.
  - `out_operand` and `out_op` are stable while `out_valid`=1.
  - `out_valid` is independent of `out_ready`.
- **Reset**: all outputs 0; both FSMs go to IDLE/ENTRY and counters go to 0. Reset in any state aborts a pending token without handshake.

## Timing
- Fully synchronous to `clk`; no combinational path from any input to any output.
- Press latency: with `key_valid`=1 and a constant code on cycles t..t+N-1 (N = DEBOUNCE_CYCLES), the internal `press` is registered at t+N.
  - `entry_bcd`, `entry_count`, `overflow` update, and `out_valid` rises, visible at t+N+1.
- Token acceptance: handshake at cycle h gives `out_valid`=0 at h+1. A press registered at h+1 or later is processed normally.
- Press and acceptance in the same cycle: the press is discarded (state is still SEND).
- Debounce counter width is ceil(log2(DEBOUNCE_CYCLES+1)); it saturates and never wraps.

## Structure
- Package `keypad_pkg` holds:
  - key code constants (`KEY_ADD`=4'hA … `KEY_EQ`=4'hF, `KEY_CLR`=4'hE);
  - `out_op` encoding constants;
  - the debounce and entry FSM state enums.
- Sub-module `key_debounce`: debounce FSM and counter. It outputs `press` (1) and `press_code` (4) and is parameterised by DEBOUNCE_CYCLES.
- Top `keypad_entry` holds the entry FSM, digit shift register and output register.

## Test plan
- Clean press of `5` held 3×N cycles, then clean release → exactly one press; `entry_bcd`=0x0005, `entry_count`=1 at t+N+1.
- Bounce: `key_valid` toggles every 3 cycles for 50 cycles with N=20, then stays low → no press and no state change.
- Digits 0,1,2,3,4,5 with NDIGITS=4 → leading 0 ignored; `entry_bcd`=0x1234, `entry_count`=4; `5` dropped and `overflow`=1.
- Enter 12, then A with `out_ready`=0 for 10 cycles → `out_valid` held with `out_operand`=0x0012, `out_op`=0.
  - A press of 7 during the wait is discarded.
  - After `out_ready`=1, the next press of 7 gives `entry_bcd`=0x0007.
- Enter 9, then E, then F → token `out_operand`=0, `out_op`=4.
- Assert `rst` for one cycle while in SEND → next cycle all outputs 0 and `out_valid`=0; a subsequent press of 3 gives `entry_bcd`=0x0003.
